decoder_reg_n: RTL and testbench
================================

Name: decoder_reg_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; successor to the fixed 2-to-4 enable decoder.
- Drives per-register write enables in the register file write path.
- One cycle of latency, a stall/hold input, and level or pulse output modes.
- Optional hardwired-zero suppression: writes to the zero register (X31) never assert an enable.

Parameters:
- IN_W, 5, select width; output width is 2**IN_W (derived, not overridable).
- HOLD_MODE, 0, 0 = pulse mode (d clears when idle), 1 = level mode (d holds the last decode when idle).
- MASK_EN, 1, 1 = decode of MASK_IDX is suppressed.
- MASK_IDX, 31, index whose decode is suppressed when MASK_EN=1; must be < 2**IN_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- i  input  IN_W  select index
- enable  input  1  request: decode i this cycle
- stall  input  1  freeze all outputs and registered state
- d  output  2**IN_W  registered one-hot decode (all-zero when idle/masked)
- valid  output  1  high for one cycle per accepted request (registered)
- mask_hit  output  1  high for one cycle when an accepted request hit MASK_IDX with MASK_EN=1

Behaviour:
- All state updates on the rising clk edge. No combinational path from inputs to outputs.
- Priority per edge: reset > stall > enable > idle.
- Reset is sampled synchronously; reset=1 at an edge forces d=0, valid=0, mask_hit=0. Nothing clears asynchronously.
- Reset asserted mid-operation (including during stall) clears everything at that edge; the in-flight request is dropped.
- Stall (reset=0, stall=1):
  - d, valid and mask_hit hold their current values.
  - enable and i are ignored; the request is not captured and not queued.
  - The requester must hold enable until stall is low.
- Accept (reset=0, stall=0, enable=1), one cycle latency:
  - Unmasked case: next d = 1<<i, valid=1, mask_hit=0.
  - If MASK_EN=1 and i==MASK_IDX: next d = all-zero, valid=1, mask_hit=1.
- Idle (reset=0, stall=0, enable=0):
  - valid=0 and mask_hit=0 next cycle.
  - HOLD_MODE=0: d=0.
  - HOLD_MODE=1: d holds the last accepted decode. A masked decode leaves d at 0.
- Back-to-back requests on consecutive cycles each produce a one-cycle valid; d switches directly from one one-hot to the next with no zero cycle between.
- Invariant: popcount(d) <= 1 at all times.
- Invariant: d != 0 implies either valid=1 this cycle, or HOLD_MODE=1 and no reset since the last unmasked accept.
- Boundaries:
  - i = 0 decodes to d[0].
  - i = 2**IN_W-1 decodes to the MSB, unless it equals MASK_IDX with MASK_EN=1.
  - With MASK_EN=0, MASK_IDX is ignored entirely.
- X on i while enable=0 or stall=1 must not propagate to d.

Test Plan:
- Reset then sweep, defaults: hold reset 2 cycles, then d=0 and valid=0; enable=1 with i=0,1,2,...,30 on consecutive cycles -> the cycle after each, d=1<<i and valid=1; after i=30, drop enable -> d=0, valid=0 (pulse mode).
- Masked index, defaults: enable=1, i=31 -> next cycle d=0, valid=1, mask_hit=1. Rerun with MASK_EN=0 -> d=32'h8000_0000, mask_hit=0.
- Stall: accept i=5 so d=32'h20; then stall=1 for 3 cycles while enable=1, i=9 -> d stays 32'h20, valid stays 1, no capture of 9; drop stall with enable=1, i=9 -> next cycle d=32'h200.
- Hold mode, HOLD_MODE=1, IN_W=2: accept i=2 -> d=4'b0100, valid=1; idle 4 cycles -> d=4'b0100, valid=0; accept i=3 -> d=4'b1000.
- Reset priority: with stall=1 and d=32'h20, assert reset for 1 cycle -> next edge d=0, valid=0, mask_hit=0. Reset and enable together -> d=0.
- Random regression, IN_W=3 and IN_W=5: 1000 cycles of random enable, stall and i, checked against a reference model every cycle; also check popcount(d) <= 1 every cycle.

Source files
------------

// File: rtl/decoder_reg_n.sv
// decoder_reg_n: registered N-to-2^N one-hot decoder for register-file write enables.
// One cycle of latency. Stall freezes everything. Pulse or level output mode.
// An optional masked index (typically the hardwired-zero register) never
// asserts an enable.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   i        select index (IN_W bits)
//   enable   request: decode i this cycle
//   stall    freeze all outputs and registered state
//   d        registered one-hot decode, 2**IN_W bits (all-zero when idle/masked)
//   valid    one cycle per accepted request
//   mask_hit one cycle when an accepted request hit MASK_IDX with MASK_EN=1
module decoder_reg_n #(
  parameter int unsigned IN_W      = 5,
  parameter int unsigned HOLD_MODE = 0,
  parameter int unsigned MASK_EN   = 1,
  parameter int unsigned MASK_IDX  = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_W-1:0]      i,
  input  logic                 enable,
  input  logic                 stall,
  output logic [(2**IN_W)-1:0] d,
  output logic                 valid,
  output logic                 mask_hit
);

  localparam int unsigned OUT_W = 2**IN_W;

  logic [OUT_W-1:0] d_nxt;
  logic             valid_nxt;
  logic             mask_hit_nxt;
  logic             hit_c;

  // Request targets the suppressed index; never consulted unless enable=1.
  assign hit_c = (MASK_EN != 0) && (i == IN_W'(MASK_IDX));

  // Next-state selection: stall > enable > idle (reset handled in the register).
  always_comb begin
    d_nxt        = d;
    valid_nxt    = valid;
    mask_hit_nxt = mask_hit;
    if (!stall) begin
      if (enable) begin
        valid_nxt    = 1'b1;
        mask_hit_nxt = hit_c;
        d_nxt        = hit_c ? '0 : (OUT_W'(1) << i);
      end else begin
        valid_nxt    = 1'b0;
        mask_hit_nxt = 1'b0;
        // Level mode keeps the last decode; a masked decode already left d at 0.
        if (HOLD_MODE == 0) begin
          d_nxt = '0;
        end
      end
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      d        <= '0;
      valid    <= 1'b0;
      mask_hit <= 1'b0;
    end else begin
      d        <= d_nxt;
      valid    <= valid_nxt;
      mask_hit <= mask_hit_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_reg_n.sv
// Self-checking bench for decoder_reg_n across four parameterisations:
//   u0: defaults (IN_W=5, pulse, mask 31)      u1: IN_W=5, MASK_EN=0
//   u2: IN_W=2, level mode, no mask            u3: IN_W=3, level mode, mask 5
module tb_decoder_reg_n;

  logic clk;
  logic rst [4];
  logic stl [4];
  logic en  [4];
  logic [4:0] idx [4];

  logic [31:0] d0, d1;
  logic [3:0]  d2;
  logic [7:0]  d3;
  logic v0, v1, v2, v3, m0, m1, m2, m3;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expectation for the next edge, pushed when stimulus is driven.
  int          kq [$];
  string       tq [$];
  logic [33:0] eq [$];

  logic [33:0] st [4];

  decoder_reg_n u0 (.clk(clk), .reset(rst[0]), .i(idx[0]), .enable(en[0]),
                    .stall(stl[0]), .d(d0), .valid(v0), .mask_hit(m0));

  decoder_reg_n #(.IN_W(5), .MASK_EN(0)) u1 (
    .clk(clk), .reset(rst[1]), .i(idx[1]), .enable(en[1]),
    .stall(stl[1]), .d(d1), .valid(v1), .mask_hit(m1));

  decoder_reg_n #(.IN_W(2), .HOLD_MODE(1), .MASK_EN(0), .MASK_IDX(0)) u2 (
    .clk(clk), .reset(rst[2]), .i(idx[2][1:0]), .enable(en[2]),
    .stall(stl[2]), .d(d2), .valid(v2), .mask_hit(m2));

  decoder_reg_n #(.IN_W(3), .HOLD_MODE(1), .MASK_EN(1), .MASK_IDX(5)) u3 (
    .clk(clk), .reset(rst[3]), .i(idx[3][2:0]), .enable(en[3]),
    .stall(stl[3]), .d(d3), .valid(v3), .mask_hit(m3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] obs(input int k);
    case (k)
      0:       return {d0, v0, m0};
      1:       return {d1, v1, m1};
      2:       return {28'b0, d2, v2, m2};
      default: return {24'b0, d3, v3, m3};
    endcase
  endfunction

  // Reference behaviour: {d, valid, mask_hit} after one edge.
  function automatic logic [33:0] model(input logic [33:0] cur, input int hold,
                                        input int men, input int midx,
                                        input logic r, input logic s,
                                        input logic e, input int unsigned x);
    logic [31:0] onehot;
    if (r) return '0;
    if (s) return cur;
    if (e) begin
      if (men != 0 && x == midx) return {32'b0, 1'b1, 1'b1};
      onehot = 32'b0;
      onehot[x] = 1'b1;
      return {onehot, 1'b1, 1'b0};
    end
    if (hold != 0) return {cur[33:2], 2'b00};
    return '0;
  endfunction

  task automatic expect_next(input int k, input string tag, input logic [31:0] ed,
                             input logic ev, input logic em);
    kq.push_back(k);
    tq.push_back(tag);
    eq.push_back({ed, ev, em});
  endtask

  // Advance one edge, sample 1 time unit later, drain the scoreboard.
  task automatic tick();
    int k;
    string t;
    logic [33:0] e, o;
    @(posedge clk);
    #1;
    while (kq.size() > 0) begin
      k = kq.pop_front();
      t = tq.pop_front();
      e = eq.pop_front();
      o = obs(k);
      checks++;
      assert (o === e) else begin
        failures++;
        $error("FAIL %s u%0d got d=%h v=%b m=%b exp d=%h v=%b m=%b",
               t, k, o[33:2], o[1], o[0], e[33:2], e[1], e[0]);
      end
    end
    for (int j = 0; j < 4; j++) begin
      o = obs(j);
      checks++;
      assert ($countones(o[33:2]) <= 1) else begin
        failures++;
        $error("FAIL onehot u%0d got d=%h exp popcount<=1", j, o[33:2]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; stl[k] = 1'b0; en[k] = 1'b0; idx[k] = 5'd0;
    end

    // Reset held for two edges.
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 4; k++) expect_next(k, "reset", 32'h0, 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;

    // Back-to-back sweep of i=0..30 on u0, then idle clears d (pulse mode).
    for (int n = 0; n <= 30; n++) begin
      en[0] = 1'b1; idx[0] = 5'(n);
      expect_next(0, "sweep", 32'h1 << n, 1'b1, 1'b0);
      tick();
    end
    en[0] = 1'b0; idx[0] = 5'd17;
    expect_next(0, "idle_pulse", 32'h0, 1'b0, 1'b0);
    tick();

    // Index 31: masked on u0, plain MSB decode on u1.
    en[0] = 1'b1; idx[0] = 5'd31;
    en[1] = 1'b1; idx[1] = 5'd31;
    expect_next(0, "mask_hit", 32'h0, 1'b1, 1'b1);
    expect_next(1, "nomask_msb", 32'h8000_0000, 1'b1, 1'b0);
    tick();
    en[0] = 1'b0; en[1] = 1'b0;
    expect_next(0, "mask_idle", 32'h0, 1'b0, 1'b0);
    expect_next(1, "nomask_idle", 32'h0, 1'b0, 1'b0);
    tick();

    // Stall freezes outputs and ignores the pending request.
    en[0] = 1'b1; idx[0] = 5'd5;
    expect_next(0, "accept5", 32'h20, 1'b1, 1'b0);
    tick();
    stl[0] = 1'b1; idx[0] = 5'd9;
    for (int n = 0; n < 3; n++) begin
      expect_next(0, "stall_hold", 32'h20, 1'b1, 1'b0);
      tick();
    end
    stl[0] = 1'b0;
    expect_next(0, "post_stall9", 32'h200, 1'b1, 1'b0);
    tick();

    // Reset beats stall, and reset beats enable.
    idx[0] = 5'd5;
    expect_next(0, "accept5b", 32'h20, 1'b1, 1'b0);
    tick();
    stl[0] = 1'b1; rst[0] = 1'b1;
    expect_next(0, "reset_in_stall", 32'h0, 1'b0, 1'b0);
    tick();
    rst[0] = 1'b0;
    expect_next(0, "stall_after_rst", 32'h0, 1'b0, 1'b0);
    tick();
    stl[0] = 1'b0; rst[0] = 1'b1; idx[0] = 5'd7;
    expect_next(0, "reset_and_en", 32'h0, 1'b0, 1'b0);
    tick();
    rst[0] = 1'b0; en[0] = 1'b0;
    expect_next(0, "post_reset_idle", 32'h0, 1'b0, 1'b0);
    tick();

    // Level mode on u2: decode persists through idle with any i.
    en[2] = 1'b1; idx[2] = 5'd2;
    expect_next(2, "hold_acc2", 32'h4, 1'b1, 1'b0);
    tick();
    en[2] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      idx[2] = 5'(n);
      expect_next(2, "hold_idle", 32'h4, 1'b0, 1'b0);
      tick();
    end
    en[2] = 1'b1; idx[2] = 5'd3;
    expect_next(2, "hold_acc3", 32'h8, 1'b1, 1'b0);
    tick();
    en[2] = 1'b0;
    expect_next(2, "hold_idle3", 32'h8, 1'b0, 1'b0);
    tick();

    // u3: MSB boundary, masked decode clears a held value, and stays cleared.
    en[3] = 1'b1; idx[3] = 5'd7;
    expect_next(3, "w3_msb", 32'h80, 1'b1, 1'b0);
    tick();
    idx[3] = 5'd5;
    expect_next(3, "w3_mask", 32'h0, 1'b1, 1'b1);
    tick();
    en[3] = 1'b0;
    expect_next(3, "w3_mask_idle", 32'h0, 1'b0, 1'b0);
    tick();
    en[3] = 1'b1; idx[3] = 5'd0;
    expect_next(3, "w3_zero", 32'h1, 1'b1, 1'b0);
    tick();

    // Random regression on u0 (IN_W=5) and u3 (IN_W=3) from a fresh reset.
    rst[0] = 1'b1; rst[3] = 1'b1; en[0] = 1'b0; en[3] = 1'b0;
    stl[0] = 1'b0; stl[3] = 1'b0;
    expect_next(0, "rnd_reset", 32'h0, 1'b0, 1'b0);
    expect_next(3, "rnd_reset", 32'h0, 1'b0, 1'b0);
    tick();
    st[0] = '0; st[3] = '0;
    for (int n = 0; n < 1000; n++) begin
      rst[0] = ($urandom_range(0, 49) == 0);
      stl[0] = ($urandom_range(0, 3) == 0);
      en[0]  = 1'($urandom_range(0, 1));
      idx[0] = 5'($urandom_range(0, 31));
      st[0]  = model(st[0], 0, 1, 31, rst[0], stl[0], en[0], 32'(idx[0]));
      expect_next(0, "rnd_w5", st[0][33:2], st[0][1], st[0][0]);

      rst[3] = ($urandom_range(0, 49) == 0);
      stl[3] = ($urandom_range(0, 3) == 0);
      en[3]  = 1'($urandom_range(0, 1));
      idx[3] = 5'($urandom_range(0, 7));
      st[3]  = model(st[3], 1, 1, 5, rst[3], stl[3], en[3], 32'(idx[3]));
      expect_next(3, "rnd_w3", st[3][33:2], st[3][1], st[3][0]);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
